spi_slave_sync: RTL and testbench



---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_sync_if.sv | 11 +
 rtl/spi_sync_edge.sv | 22 ++
 rtl/spi_slave_sync.sv | 135 +++++++++++++
 tb/tb_spi_slave_sync.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI slave.
package spi_pkg;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} spi_state_t;
    typedef enum logic {EDGE_LEAD = 1'b0, EDGE_TRAIL = 1'b1} spi_edge_t;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam logic [7:0] FILL_DEFAULT = 8'hFF;

    function automatic spi_edge_t sample_edge(input logic cpha);
        return cpha ? EDGE_TRAIL : EDGE_LEAD;
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// SPI bus as seen by the slave; the pad-level tristate is built from o_miso/o_miso_oe.
interface spi_slave_sync_if;
    logic i_sck;
    logic i_ss_n;
    logic i_mosi;
    logic o_miso;
    logic o_miso_oe;

    modport master (output i_sck, i_ss_n, i_mosi, input o_miso, o_miso_oe);
    modport slave  (input i_sck, i_ss_n, i_mosi, output o_miso, o_miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a trailing delay flop for rise/fall detection.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    // [SYNC_STAGES-1] is the last sync stage, [SYNC_STAGES] the edge-compare flop
    logic [SYNC_STAGES:0] r_pipe;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) r_pipe <= {(SYNC_STAGES+1){i_rst_val}};
        else           r_pipe <= {r_pipe[SYNC_STAGES-1:0], i_d};
    end

    assign o_rise =  r_pipe[SYNC_STAGES-1] & ~r_pipe[SYNC_STAGES];
    assign o_fall = ~r_pipe[SYNC_STAGES-1] &  r_pipe[SYNC_STAGES];
endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave fully clocked by i_sys_clk: oversampled SCK/SS/MOSI, one-entry TX holding
// register, unified shift register for both bit orders.
module spi_slave_sync import spi_pkg::*; #(
    parameter int             DW          = 8,
    parameter logic [DW-1:0]  FILL        = DW'(FILL_DEFAULT),
    parameter int             SYNC_STAGES = 2
) (
    input  logic          i_sys_clk,
    input  logic          i_sys_rst,
    input  logic          i_cpol,
    input  logic          i_cpha,
    input  logic          i_lsb_first,
    input  logic [DW-1:0] i_tx_data,
    input  logic          i_tx_valid,
    output logic          o_tx_ready,
    output logic [DW-1:0] o_rx_data,
    output logic          o_rx_valid,
    output logic          o_underrun,
    output logic          o_frame_err,
    output logic          o_busy,
    spi_slave_sync_if.slave bus
);
    localparam int CW = $clog2(DW+1);

    spi_state_t       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [DW-1:0]    r_shift, r_hold, r_rx_data;
    logic             r_hold_full, r_rx_valid, r_underrun, r_frame_err, r_miso;
    logic             r_cpol, r_cpha, r_lsb;
    logic [SYNC_STAGES-1:0] r_mosi_pipe;

    logic w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;
    logic w_cpol, w_cpha, w_lsb, w_lead, w_trail, w_sample, w_drive;
    logic w_start, w_end, w_done, w_load, w_wr, w_mosi, w_first_bit, w_out_bit;
    logic [DW-1:0] w_load_word, w_shift_in;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .i_sys_clk(i_sys_clk), .i_sys_rst(i_sys_rst), .i_rst_val(i_cpol),
        .i_d(bus.i_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
        .i_sys_clk(i_sys_clk), .i_sys_rst(i_sys_rst), .i_rst_val(1'b1),
        .i_d(bus.i_ss_n), .o_rise(w_ss_rise), .o_fall(w_ss_fall));

    // Same depth as the SCK synchronizer so the sampled bit lines up with the detected edge
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) r_mosi_pipe <= '0;
        else           r_mosi_pipe <= {r_mosi_pipe[SYNC_STAGES-2:0], bus.i_mosi};
    end
    assign w_mosi = r_mosi_pipe[SYNC_STAGES-1];

    // Mode pins are live only in IDLE; the frame runs on the latched copy
    assign w_cpol = (r_state == IDLE) ? i_cpol      : r_cpol;
    assign w_cpha = (r_state == IDLE) ? i_cpha      : r_cpha;
    assign w_lsb  = (r_state == IDLE) ? i_lsb_first : r_lsb;

    assign w_lead   = w_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail  = w_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample = (sample_edge(w_cpha) == EDGE_LEAD) ? w_lead  : w_trail;
    assign w_drive  = (sample_edge(w_cpha) == EDGE_LEAD) ? w_trail : w_lead;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        case (r_state)
            IDLE:    if (w_ss_fall) begin w_state_nxt = XFER; w_start = 1'b1; end
            XFER:    if (w_ss_rise) begin w_state_nxt = IDLE; w_end   = 1'b1; end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_done      = (r_state == XFER) && (r_cnt == CW'(DW));
    assign w_load      = w_start || (w_done && !w_end);
    assign w_wr        = i_tx_valid && !r_hold_full;
    assign w_load_word = r_hold_full ? r_hold : FILL;
    assign w_first_bit = w_lsb ? w_load_word[0] : w_load_word[DW-1];
    assign w_out_bit   = r_lsb ? r_shift[0]     : r_shift[DW-1];
    assign w_shift_in  = r_lsb ? {w_mosi, r_shift[DW-1:1]} : {r_shift[DW-2:0], w_mosi};

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_cnt <= '0; r_shift <= '0; r_hold <= '0; r_hold_full <= 1'b0;
            r_rx_data <= '0; r_rx_valid <= 1'b0; r_underrun <= 1'b0; r_frame_err <= 1'b0;
            r_miso <= 1'b0; r_cpol <= 1'b0; r_cpha <= 1'b0; r_lsb <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == IDLE) begin
                r_cpol <= i_cpol; r_cpha <= i_cpha; r_lsb <= i_lsb_first;
            end
            // A write in a load cycle lands after the load has taken the old contents
            if (w_wr) begin
                r_hold      <= i_tx_data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_done) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end
            if (w_end) begin
                r_cnt       <= '0;
                r_miso      <= 1'b0;
                r_frame_err <= (r_cnt != '0) && !w_done;
            end else if (w_load) begin
                r_shift    <= w_load_word;
                r_underrun <= !r_hold_full;
                r_cnt      <= '0;
                if (!w_cpha) r_miso <= w_first_bit;
            end else if (r_state == XFER && w_sample) begin
                r_shift <= w_shift_in;
                r_cnt   <= r_cnt + CW'(1);
            end else if (r_state == XFER && w_drive) begin
                r_miso <= w_out_bit;
            end
        end
    end

    assign o_tx_ready    = !r_hold_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_underrun    = r_underrun;
    assign o_frame_err   = r_frame_err;
    assign o_busy        = (r_state == XFER);
    assign bus.o_miso    = r_miso;
    assign bus.o_miso_oe = (r_state == XFER);
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: a bit-banged master on the interface, SCK half-period of 4 system clocks.
module tb_spi_slave_sync;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpol, cpha, lsb;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, rx_valid, underrun, frame_err, busy;
    logic [7:0] rx_data;

    int n_chk = 0, n_err = 0;
    int n_rxv = 0, n_ur = 0, n_fe = 0;
    int ur_snap, rxv0, ur0, fe0;
    logic [15:0] mrx;

    always #5 clk = ~clk;

    spi_slave_sync_if bus();

    spi_slave_sync #(.DW(8), .FILL(8'hFF), .SYNC_STAGES(2)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_cpol(cpol), .i_cpha(cpha), .i_lsb_first(lsb),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .o_underrun(underrun), .o_frame_err(frame_err), .o_busy(busy),
        .bus(bus.slave));

    // pulse counters; bench tasks compare deltas across a frame
    always @(negedge clk) begin
        if (rx_valid)  n_rxv <= n_rxv + 1;
        if (underrun)  n_ur  <= n_ur + 1;
        if (frame_err) n_fe  <= n_fe + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic hw(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    function automatic int bidx(input int j);
        return (j / 8) * 8 + (lsb ? (j % 8) : 7 - (j % 8));
    endfunction

    // nbits SCK cycles under SS; word 0 in tx[7:0], word 1 in tx[15:8]
    task automatic frame(input int nbits, input logic [15:0] tx,
                         input bit w1, input logic [7:0] d1,
                         input bit w2, input logic [7:0] d2,
                         output logic [15:0] rx);
        rx = '0;
        bus.i_ss_n = 1'b0;
        if (!cpha) bus.i_mosi = tx[bidx(0)];
        hw(8);
        ur_snap = n_ur;
        if (w1) wr(d1);
        for (int j = 0; j < nbits; j++) begin
            if (!cpha) begin
                rx[bidx(j)] = bus.o_miso;
                bus.i_sck = ~cpol; hw(4);
                bus.i_sck = cpol;
                if (j + 1 < nbits) bus.i_mosi = tx[bidx(j+1)];
                hw(4);
            end else begin
                bus.i_sck = ~cpol; bus.i_mosi = tx[bidx(j)]; hw(4);
                rx[bidx(j)] = bus.o_miso;
                bus.i_sck = cpol; hw(4);
            end
            if (j == 7 && w2) wr(d2);
        end
        bus.i_ss_n = 1'b1;
        bus.i_mosi = 1'b0;
        hw(8);
    endtask

    initial begin
        rst = 1'b1; {cpol, cpha} = SPI_MODE0; lsb = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        bus.i_sck = 1'b0; bus.i_ss_n = 1'b1; bus.i_mosi = 1'b0;
        hw(3);
        rst = 1'b0;
        hw(1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_rxdata", rx_data, 0);
        chk("rst_rxvalid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_oe", bus.o_miso_oe, 0);
        chk("rst_miso", bus.o_miso, 0);

        // mode 0, MSB first
        wr(8'h3C);
        chk("m0_ready_full", tx_ready, 0);
        rxv0 = n_rxv; fe0 = n_fe;
        frame(8, 16'h00A5, 0, 8'h00, 0, 8'h00, mrx);
        chk("m0_rxdata", rx_data, 8'hA5);
        chk("m0_rxv_cnt", n_rxv - rxv0, 1);
        chk("m0_miso", mrx[7:0], 8'h3C);
        chk("m0_ferr", n_fe - fe0, 0);
        chk("m0_busy_end", busy, 0);
        chk("m0_oe_end", bus.o_miso_oe, 0);

        // mode 3, LSB first
        {cpol, cpha} = SPI_MODE3; lsb = 1'b1; bus.i_sck = 1'b1;
        hw(8);
        wr(8'h81);
        rxv0 = n_rxv;
        frame(8, 16'h000F, 0, 8'h00, 0, 8'h00, mrx);
        chk("m3_rxdata", rx_data, 8'h0F);
        chk("m3_miso", mrx[7:0], 8'h81);
        chk("m3_rxv_cnt", n_rxv - rxv0, 1);

        // back-to-back words under one SS
        {cpol, cpha} = SPI_MODE0; lsb = 1'b0; bus.i_sck = 1'b0;
        hw(8);
        wr(8'h11);
        rxv0 = n_rxv; ur0 = n_ur;
        frame(16, 16'h96C3, 1, 8'h22, 1, 8'h33, mrx);
        chk("b2b_miso", mrx, 16'h2211);
        chk("b2b_rxv_cnt", n_rxv - rxv0, 2);
        chk("b2b_underrun", n_ur - ur0, 0);
        chk("b2b_rxdata", rx_data, 8'h96);

        // empty holding register at SS fall
        ur0 = n_ur;
        frame(8, 16'h0000, 0, 8'h00, 0, 8'h00, mrx);
        chk("ur_pulse_at_start", ur_snap - ur0, 1);
        chk("ur_miso", mrx[7:0], 8'hFF);

        // SS rises after 5 sample edges
        rxv0 = n_rxv; fe0 = n_fe;
        frame(5, 16'h00E7, 0, 8'h00, 0, 8'h00, mrx);
        chk("ab_ferr", n_fe - fe0, 1);
        chk("ab_rxv_cnt", n_rxv - rxv0, 0);
        chk("ab_oe", bus.o_miso_oe, 0);
        chk("ab_busy", busy, 0);
        frame(8, 16'h006B, 0, 8'h00, 0, 8'h00, mrx);
        chk("ab_next_rxdata", rx_data, 8'h6B);
        chk("ab_next_rxv", n_rxv - rxv0, 1);

        // reset after 3 bits of a frame
        bus.i_ss_n = 1'b0; bus.i_mosi = 1'b1;
        hw(8);
        wr(8'h77);
        chk("rs_ready_full", tx_ready, 0);
        for (int j = 0; j < 3; j++) begin
            bus.i_sck = 1'b1; hw(4);
            bus.i_sck = 1'b0; hw(4);
        end
        chk("rs_busy_pre", busy, 1);
        fe0 = n_fe; rxv0 = n_rxv;
        rst = 1'b1;
        hw(1);
        chk("rs_busy", busy, 0);
        chk("rs_oe", bus.o_miso_oe, 0);
        chk("rs_ready", tx_ready, 1);
        chk("rs_rxdata", rx_data, 0);
        chk("rs_miso", bus.o_miso, 0);
        bus.i_ss_n = 1'b1; bus.i_mosi = 1'b0;
        hw(2);
        rst = 1'b0;
        hw(8);
        chk("rs_no_ferr", n_fe - fe0, 0);
        chk("rs_no_rxv", n_rxv - rxv0, 0);
        frame(8, 16'h005A, 0, 8'h00, 0, 8'h00, mrx);
        chk("rs_fresh_rxdata", rx_data, 8'h5A);
        chk("rs_fresh_rxv", n_rxv - rxv0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
